// File: rtl/seqdet_pkg.sv
// Shared defaults for the parametrised serial sequence detector.
package seqdet_pkg;
  localparam int          SEQDET_PAT_W_DEF   = 4;
  localparam logic [31:0] SEQDET_PATTERN_DEF = 32'b1001;
  localparam int          SEQDET_CNT_W_DEF   = 8;
endpackage

// File: rtl/seq_detector_param_if.sv
// Serial stream + result bus of the sequence detector.
// master: stream source / result consumer; slave: the detector.
interface seq_detector_param_if import seqdet_pkg::*; #(
  parameter int CNT_W = SEQDET_CNT_W_DEF
) ();
  logic             x;
  logic             valid;
  logic             overlap;
  logic             cnt_clr;
  logic             y;
  logic [CNT_W-1:0] match_cnt;

  modport master (output x, valid, overlap, cnt_clr, input y, match_cnt);
  modport slave  (input x, valid, overlap, cnt_clr, output y, match_cnt);
endinterface

// File: rtl/seqdet_window.sv
// History shift register, fill counter and pattern compare.
// hit is combinational and already qualified by the accept strobe.
module seqdet_window import seqdet_pkg::*; #(
  parameter int               PAT_W   = SEQDET_PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(SEQDET_PATTERN_DEF)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic acc,
  input  logic x,
  input  logic overlap,
  output logic hit
);
  // fill spans 0..PAT_W-1, which always fits in clog2(PAT_W) bits
  localparam int FW = $clog2(PAT_W);
  localparam logic [FW-1:0] FULL = FW'(PAT_W - 1);

  logic [PAT_W-2:0] win;
  logic [FW-1:0]    fill;
  logic [PAT_W-1:0] cand;

  assign cand = {win, x};
  assign hit  = acc && (fill == FULL) && (cand == PATTERN);

  // Shift accepted bits in; a non-overlapping hit forces PAT_W fresh bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win  <= '0;
      fill <= '0;
    end else if (acc) begin
      win <= cand[PAT_W-2:0];
      if (hit && !overlap)
        fill <= '0;
      else if (fill != FULL)
        fill <= fill + 1'b1;
    end
  end
endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector: registered one-cycle match pulse
// plus an optional saturating match counter.
// Counter built only when SEQDET_MATCH_CNT_EN is defined; otherwise
// match_cnt is tied to 0 and cnt_clr is ignored (same port list).
module seq_detector_param import seqdet_pkg::*; #(
  parameter int               PAT_W   = SEQDET_PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(SEQDET_PATTERN_DEF),
  parameter int               CNT_W   = SEQDET_CNT_W_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  seq_detector_param_if.slave bus
);
  logic hit;

  seqdet_window #(.PAT_W(PAT_W), .PATTERN(PATTERN)) u_win (
    .clk     (clk),
    .rst_n   (rst_n),
    .acc     (bus.valid),
    .x       (bus.x),
    .overlap (bus.overlap),
    .hit     (hit)
  );

  // Match pulse: one cycle after the accepting edge, low on idle cycles
  always_ff @(posedge clk) begin
    if (!rst_n) bus.y <= 1'b0;
    else        bus.y <= hit;
  end

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt;

  // Clear wins over increment, but a hit on the clear cycle still counts
  always_ff @(posedge clk) begin
    if (!rst_n)                    cnt <= '0;
    else if (bus.cnt_clr && hit)   cnt <= CNT_W'(1);
    else if (bus.cnt_clr)          cnt <= '0;
    else if (hit && (cnt != '1))   cnt <= cnt + 1'b1;
  end

  assign bus.match_cnt = cnt;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = bus.cnt_clr;
  assign bus.match_cnt  = '0;
`endif
endmodule
